// File: rtl/booth_sched_pkg.sv
// ---------------------------------------------------------------------------
// booth_sched_pkg
// Purpose : Shared definitions for the booth multiplier scheduler: FSM state
//           encoding and the default N / R / MUL_LAT values.
// Ports   : none (package).
// ---------------------------------------------------------------------------
package booth_sched_pkg;

  // Default operand width, requester count and booth latency.
  localparam int DEF_N       = 8;
  localparam int DEF_R       = 4;
  localparam int DEF_MUL_LAT = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/booth_mul_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purpose : Combinational round-robin arbiter. The requester just after ptr
//           has the highest priority, wrapping round to ptr itself last.
//           The pointer register lives in the parent.
// Ports   :
//   req   in  R    request vector
//   ptr   in  IDW  index of the most recently granted requester
//   grant out R    one-hot grant (all zero when no request)
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int R   = 4,
  parameter int IDW = $clog2(R)
) (
  input  logic [R-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [R-1:0]   grant
);

  // Two spare bits hold gi + R - 1 (at most 2R-2) without overflow.
  localparam int DW = IDW + 2;

  // Priority distance of each requester from the pointer: 0 = served next.
  logic [DW-1:0] w_dist [R];

  genvar gi, gj;
  generate
    for (gi = 0; gi < R; gi++) begin : g_dist
      logic [DW-1:0] w_raw;
      // (gi - ptr - 1) mod R, done without a divider so R need not be a
      // power of two.
      assign w_raw       = DW'(gi + R - 1) - DW'(ptr);
      assign w_dist[gi]  = (w_raw >= DW'(R)) ? (w_raw - DW'(R)) : w_raw;
    end

    for (gi = 0; gi < R; gi++) begin : g_grant
      logic [R-1:0] w_closer;
      // A requester wins unless some active requester is closer to the
      // pointer. Distances are unique, so at most one bit of grant is set.
      for (gj = 0; gj < R; gj++) begin : g_cmp
        assign w_closer[gj] = req[gj] && (w_dist[gj] < w_dist[gi]);
      end
      assign grant[gi] = req[gi] && !(|w_closer);
    end
  endgenerate

endmodule

// File: rtl/booth_mul_scheduler.sv
// ---------------------------------------------------------------------------
// booth_mul_scheduler
// Purpose : Shares one fixed-latency radix-4 booth multiplier between R
//           requesters. Round-robin accept, operand latch, one-cycle start
//           pulse, fixed wait, then a result tagged with the requester id
//           held until the consumer takes it. One operation in flight.
// Optional: define BOOTH_SCHED_ZERO_BYPASS_EN to skip the multiplier when a
//           latched operand is zero (result 0, response two cycles after
//           accept, no start pulse).
// Ports   :
//   clk        in   1     rising-edge clock
//   rst_n      in   1     asynchronous active-low reset
//   req_valid  in   R     per-requester request, held until req_ready
//   req_ready  out  R     one-hot accept (combinational, IDLE only)
//   req_m      in   R*N   multiplicands, slice i = [i*N +: N]
//   req_q      in   R*N   multipliers,   slice i = [i*N +: N]
//   rsp_valid  out  1     result valid, held until rsp_ready
//   rsp_ready  in   1     consumer accepts result
//   rsp_id     out  IDW   owner of rsp_data
//   rsp_data   out  2N    signed product
//   mul_start  out  1     start pulse to the booth instance
//   mul_m      out  N     latched multiplicand to booth
//   mul_q      out  N     latched multiplier to booth
//   mul_ans    in   2N    booth product
//   busy       out  1     operation in progress
// ---------------------------------------------------------------------------
module booth_mul_scheduler
  import booth_sched_pkg::*;
#(
  parameter int  N       = DEF_N,
  parameter int  R       = DEF_R,
  parameter int  MUL_LAT = DEF_MUL_LAT,
  localparam int IDW     = $clog2(R)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [R-1:0]     req_valid,
  output logic [R-1:0]     req_ready,
  input  logic [R*N-1:0]   req_m,
  input  logic [R*N-1:0]   req_q,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [IDW-1:0]   rsp_id,
  output logic [2*N-1:0]   rsp_data,
  output logic             mul_start,
  output logic [N-1:0]     mul_m,
  output logic [N-1:0]     mul_q,
  input  logic [2*N-1:0]   mul_ans,
  output logic             busy
);

  // Counter must hold MUL_LAT-1; +1 keeps the width non-zero for MUL_LAT=1.
  localparam int CW = $clog2(MUL_LAT + 1);

  state_t         r_state;
  state_t         w_state_next;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_id;
  logic [N-1:0]   r_m;
  logic [N-1:0]   r_q;
  logic [CW-1:0]  r_cnt;
  logic [2*N-1:0] r_rsp_data;
  logic           r_rsp_valid;

  logic [R-1:0]   w_grant;
  logic [IDW-1:0] w_gidx;
  logic [N-1:0]   w_sel_m;
  logic [N-1:0]   w_sel_q;
  logic           w_accept;
  logic           w_bypass;
  logic           w_mul_start;

  rr_arbiter #(
    .R   (R),
    .IDW (IDW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (r_ptr),
    .grant (w_grant)
  );

  // One-hot grant -> index and operand mux.
  always_comb begin
    w_sel_m = '0;
    w_sel_q = '0;
    w_gidx  = '0;
    for (int i = 0; i < R; i++) begin
      if (w_grant[i]) begin
        w_sel_m = req_m[i*N +: N];
        w_sel_q = req_q[i*N +: N];
        w_gidx  = IDW'(i);
      end
    end
  end

  // The grant only asserts for an active request, so any grant in IDLE is
  // an accept.
  assign w_accept = (r_state == ST_IDLE) && (|w_grant);

`ifdef BOOTH_SCHED_ZERO_BYPASS_EN
  assign w_bypass = (r_m == '0) || (r_q == '0);
`else
  assign w_bypass = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and the start pulse.
  always_comb begin
    w_state_next = r_state;
    w_mul_start  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        if (w_bypass) begin
          w_state_next = ST_RESP;
        end else begin
          w_mul_start  = 1'b1;
          w_state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        // rsp_valid is always high in RESP.
        if (rsp_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Operand, id, pointer, counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= IDW'(R - 1);
      r_id        <= '0;
      r_m         <= '0;
      r_q         <= '0;
      r_cnt       <= '0;
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_m   <= w_sel_m;
            r_q   <= w_sel_q;
            r_id  <= w_gidx;
            r_ptr <= w_gidx;
          end
        end
        ST_LAUNCH: begin
          r_cnt <= CW'(MUL_LAT - 1);
          if (w_bypass) begin
            r_rsp_data  <= '0;
            r_rsp_valid <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            r_rsp_data  <= mul_ans;
            r_rsp_valid <= 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready = (r_state == ST_IDLE) ? w_grant : '0;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_id;
  assign rsp_data  = r_rsp_data;
  assign mul_start = w_mul_start;
  assign mul_m     = r_m;
  assign mul_q     = r_q;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_booth_mul_scheduler.sv
// ---------------------------------------------------------------------------
// tb_booth_mul_scheduler
// Self-checking bench: a fixed-latency booth model drives mul_ans, a
// requester agent holds each request until accepted, and a cycle-level
// model (round-robin choice, accept time, latency, expected product) is
// compared against the DUT every cycle. Directed tests add literal checks.
// ---------------------------------------------------------------------------
module tb_booth_mul_scheduler;

  localparam int N       = 8;
  localparam int R       = 4;
  localparam int MUL_LAT = 6;
  localparam int IDW     = 2;

`ifdef BOOTH_SCHED_ZERO_BYPASS_EN
  localparam bit ZB = 1'b1;
`else
  localparam bit ZB = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [R-1:0]     req_valid;
  logic [R-1:0]     req_ready;
  logic [R*N-1:0]   req_m;
  logic [R*N-1:0]   req_q;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [IDW-1:0]   rsp_id;
  logic [2*N-1:0]   rsp_data;
  logic             mul_start;
  logic [N-1:0]     mul_m;
  logic [N-1:0]     mul_q;
  logic [2*N-1:0]   mul_ans;
  logic             busy;

  booth_mul_scheduler #(.N(N), .R(R), .MUL_LAT(MUL_LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_m     (req_m),
    .req_q     (req_q),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .mul_start (mul_start),
    .mul_m     (mul_m),
    .mul_q     (mul_q),
    .mul_ans   (mul_ans),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- pending requests and requester agent ----------------
  typedef struct {
    int         id;
    logic [N-1:0] m;
    logic [N-1:0] q;
  } op_t;

  op_t pend[$];

  task automatic push(input int id, input logic [N-1:0] m, input logic [N-1:0] q);
    op_t o;
    o.id = id;
    o.m  = m;
    o.q  = q;
    pend.push_back(o);
  endtask

  initial begin
    logic [R-1:0] acc;
    req_valid = '0;
    req_m     = '0;
    req_q     = '0;
    forever begin
      @(negedge clk);
      acc = rst_n ? (req_valid & req_ready) : '0;
      @(posedge clk);
      #1;
      for (int i = 0; i < R; i++) begin
        if (acc[i]) begin
          for (int k = 0; k < pend.size(); k++) begin
            if (pend[k].id == i) begin
              pend.delete(k);
              break;
            end
          end
        end
      end
      for (int i = 0; i < R; i++) begin
        req_valid[i]       = 1'b0;
        req_m[i*N +: N]    = '0;
        req_q[i*N +: N]    = '0;
        for (int k = 0; k < pend.size(); k++) begin
          if (pend[k].id == i) begin
            req_valid[i]    = 1'b1;
            req_m[i*N +: N] = pend[k].m;
            req_q[i*N +: N] = pend[k].q;
            break;
          end
        end
      end
    end
  end

  // ---------------- booth model: product valid MUL_LAT cycles after start ----
  initial begin
    int age;
    logic signed [N-1:0]   bm;
    logic signed [N-1:0]   bq;
    logic signed [2*N-1:0] bp;
    age     = -1;
    mul_ans = 16'hDEAD;
    forever begin
      @(negedge clk);
      if (!rst_n)                      age = -1;
      else if (mul_start)              age = 0;
      else if (age >= 0 && age < 1000) age++;
      bm = mul_m;
      bq = mul_q;
      bp = bm * bq;
      mul_ans = (age >= MUL_LAT) ? bp : 16'hDEAD;
    end
  end

  // ---------------- cycle-level model and compare process ----------------
  bit              m_busy = 1'b0;
  int              m_ptr  = R - 1;
  int              m_acc  = 0;
  int              m_resp_age = 0;
  bit              m_byp  = 1'b0;
  int              m_id   = 0;
  logic [N-1:0]    m_m, m_q;
  logic [2*N-1:0]  m_prod;
  int              m_starts = 0;

  int              n_rsp = 0;
  int              last_id, last_lat, last_starts;
  logic [2*N-1:0]  last_data;
  int              grant_log[$];

  initial begin
    int age, g, j;
    logic [R-1:0] exp_rdy;
    logic exp_rv, exp_start;
    logic signed [N-1:0]   sm, sq;
    logic signed [2*N-1:0] sp;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("reset_ctl",  {28'd0, busy, rsp_valid, mul_start, 1'b0} | {30'd0, rsp_id}, 32'd0);
        chk("reset_data", {rsp_data, mul_m, mul_q}, 32'd0);
        m_busy = 1'b0;
        m_ptr  = R - 1;
      end else begin
        age = cyc - m_acc;
        g   = -1;
        if (!m_busy) begin
          for (int k = 1; k <= R; k++) begin
            j = (m_ptr + k) % R;
            if (g < 0 && req_valid[j]) g = j;
          end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", {28'd0, req_ready}, {28'd0, exp_rdy});
        chk("busy", {31'd0, busy}, {31'd0, m_busy});
        exp_start = m_busy && (age == 1) && !m_byp;
        chk("mul_start", {31'd0, mul_start}, {31'd0, exp_start});
        if (mul_start) m_starts++;
        exp_rv = m_busy && (age >= m_resp_age);
        chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_rv});
        if (m_busy) begin
          chk("mul_m", {24'd0, mul_m}, {24'd0, m_m});
          chk("mul_q", {24'd0, mul_q}, {24'd0, m_q});
        end
        if (exp_rv) begin
          chk("rsp_id",   {30'd0, rsp_id}, m_id);
          chk("rsp_data", {16'd0, rsp_data}, {16'd0, m_prod});
        end
        if (exp_rv && rsp_ready) begin
          m_busy      = 1'b0;
          last_id     = int'(rsp_id);
          last_data   = rsp_data;
          last_lat    = cyc - m_acc;
          last_starts = m_starts;
          n_rsp++;
        end else if (g >= 0) begin
          m_busy     = 1'b1;
          m_acc      = cyc;
          m_ptr      = g;
          m_id       = g;
          m_m        = req_m[g*N +: N];
          m_q        = req_q[g*N +: N];
          sm         = m_m;
          sq         = m_q;
          sp         = sm * sq;
          m_prod     = sp;
          m_byp      = ZB && (m_m == '0 || m_q == '0);
          m_resp_age = m_byp ? 2 : MUL_LAT + 2;
          m_starts   = 0;
          grant_log.push_back(g);
        end
      end
    end
  end

  // ---------------- directed tests ----------------
  task automatic wait_rsp(input string name);
    int start;
    int k;
    start = n_rsp;
    k     = 0;
    while (n_rsp == start && k < 400) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (n_rsp == start) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL %s: no response within 400 cycles", name);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    int k;
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    step(3);
    rst_n = 1'b1;

    // 1: single request, latency and start count
    push(0, 8'h07, 8'hFA);
    wait_rsp("t1");
    chk("t1_id",     last_id, 0);
    chk("t1_data",   {16'd0, last_data}, 32'h0000FFD6);
    chk("t1_lat",    last_lat, 8);
    chk("t1_starts", last_starts, 1);
    $display("[TB] t1 id=%0d data=%04h lat=%0d", last_id, last_data, last_lat);

    // 2: all four requesting continuously from reset -> 0,1,2,3,0,1,2,3
    step(1);
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    grant_log.delete();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < R; i++)
        push(i, 8'(i*37 + r*11 + 5), 8'(200 - i*29 - r*7));
    for (int i = 0; i < 8; i++) begin
      wait_rsp("t2");
      $display("[TB] t2 op%0d id=%0d data=%04h", i, last_id, last_data);
      chk("t2_rsp_id", last_id, i % R);
      if (i == 2) chk("t2_data_op2", {16'd0, last_data}, 32'h0000DCD2);
    end
    chk("t2_grants", grant_log.size(), 8);
    for (int i = 0; i < grant_log.size(); i++) chk("t2_grant_order", grant_log[i], i % R);

    // 3: backpressure for 10 cycles, a second request waits behind it
    rsp_ready = 1'b0;
    push(1, 8'h0C, 8'h0D);
    k = 0;
    while (!rsp_valid && k < 100) begin
      step(1);
      k++;
    end
    chk("t3_valid_seen", {31'd0, rsp_valid}, 32'd1);
    push(2, 8'h11, 8'h02);
    step(10);
    chk("t3_hold_data",  {16'd0, rsp_data}, 32'h0000009C);
    chk("t3_hold_id",    {30'd0, rsp_id}, 32'd1);
    chk("t3_hold_ready", {28'd0, req_ready}, 32'd0);
    rsp_ready = 1'b1;
    wait_rsp("t3a");
    chk("t3_starts", last_starts, 1);
    wait_rsp("t3b");
    chk("t3b_id",   last_id, 2);
    chk("t3b_data", {16'd0, last_data}, 32'h00000022);
    $display("[TB] t3 held 10 cycles, follow-up id=%0d data=%04h", last_id, last_data);

    // 4: signed corners
    push(3, 8'h80, 8'h80);
    push(3, 8'h7F, 8'h81);
    push(3, 8'hFF, 8'hFF);
    wait_rsp("t4a");
    chk("t4_80x80", {16'd0, last_data}, 32'h00004000);
    wait_rsp("t4b");
    chk("t4_7Fx81", {16'd0, last_data}, 32'h0000C0FF);
    wait_rsp("t4c");
    chk("t4_FFxFF", {16'd0, last_data}, 32'h00000001);
    chk("t4_id", last_id, 3);
    $display("[TB] t4 corners done, last data=%04h", last_data);

    // 5: reset during WAIT abandons the operation
    push(1, 8'h03, 8'h05);
    k = 0;
    while (!mul_start && k < 100) begin
      step(1);
      k++;
    end
    step(2);
    chk("t5_busy_before", {31'd0, busy}, 32'd1);
    base  = n_rsp;
    rst_n = 1'b0;
    #1;
    chk("t5_async_ctl",  {29'd0, busy, rsp_valid, mul_start}, 32'd0);
    chk("t5_async_data", {rsp_data, mul_m, mul_q}, 32'd0);
    chk("t5_async_id",   {30'd0, rsp_id}, 32'd0);
    step(2);
    rst_n = 1'b1;
    grant_log.delete();
    push(1, 8'h02, 8'h03);
    push(0, 8'h04, 8'h05);
    wait_rsp("t5a");
    wait_rsp("t5b");
    chk("t5_rsp_count", n_rsp - base, 2);
    chk("t5_first_grant",  grant_log.size() > 0 ? grant_log[0] : -1, 0);
    chk("t5_second_grant", grant_log.size() > 1 ? grant_log[1] : -1, 1);
    $display("[TB] t5 reset mid-op, responses after release=%0d", n_rsp - base);

    // 6: zero operand
    push(2, 8'h00, 8'h55);
    wait_rsp("t6");
    chk("t6_data",   {16'd0, last_data}, 32'd0);
    chk("t6_lat",    last_lat, ZB ? 2 : MUL_LAT + 2);
    chk("t6_starts", last_starts, ZB ? 0 : 1);
    $display("[TB] t6 zero operand lat=%0d starts=%0d", last_lat, last_starts);

    step(4);
    chk("end_idle", {31'd0, busy}, 32'd0);
    chk("end_pending", pend.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
